// File: rtl/down_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse and a busy flag.
// Define DOWN_TIMER_AUTORELOAD_EN to reload from the last loaded value after reaching zero.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;

  // NOTE: all state, including the outputs, is assigned with <= so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q      <= load_val;
        reload <= load_val;
        if (load_val != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (en) begin
              if (q > WIDTH'(1)) begin
                q <= q - WIDTH'(1);
              end else if (q == WIDTH'(1)) begin
                q  <= '0;
                tc <= 1'b1;
`ifndef DOWN_TIMER_AUTORELOAD_EN
                state <= DONE;
                busy  <= 1'b0;
`endif
              end else begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
                q <= reload;
`else
                q <= '0;  // unreachable: RUN is never entered with q = 0
`endif
              end
            end
          end
          IDLE, DONE: ;  // hold until load or reset
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed vector table, corner sequences
// and a randomized run against a behavioural model.
module tb_down_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  down_timer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .q       (q),
    .tc      (tc),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] exp_q;
    logic             exp_tc;
    logic             exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: remaining count, active flag and last loaded value.
  int m_q;
  int m_reload;
  bit m_active;
  bit m_tc;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit e);
    m_tc = 1'b0;
    if (ld) begin
      m_q      = lv;
      m_reload = lv;
      m_active = (lv != 0);
    end else if (m_active && e) begin
      if (m_q == 0) begin
        m_q = m_reload;
      end else begin
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_tc = 1'b1;
`ifndef DOWN_TIMER_AUTORELOAD_EN
          m_active = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic drive(input bit ld, input int lv, input bit e);
    load     = ld;
    load_val = WIDTH'(lv);
    en       = e;
  endtask

  task automatic check_outs(input string tag, input int eq, input int etc, input int eb);
    check({tag, " q"}, int'(q), eq);
    check({tag, " tc"}, int'(tc), etc);
    check({tag, " busy"}, int'(busy), eb);
  endtask

  task automatic add(input bit ld, input int lv, input bit e, input int eq, input bit etc, input bit eb);
    vec_t v;
    v.load     = ld;
    v.load_val = WIDTH'(lv);
    v.en       = e;
    v.exp_q    = WIDTH'(eq);
    v.exp_tc   = etc;
    v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0);
    #12;
    rst = 1'b1;
    m_q = 0; m_reload = 0; m_active = 0; m_tc = 0;
    #3;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0);
    #2;
    do_reset();
    check_outs("reset", 0, 0, 0);

`ifndef DOWN_TIMER_AUTORELOAD_EN
    // one-shot: load 4
    add(1, 4, 0, 4, 0, 1);
    add(0, 0, 1, 3, 0, 1);
    add(0, 0, 1, 2, 0, 1);
    add(0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    // gated enable: load 3
    add(1, 3, 0, 3, 0, 1);
    add(0, 0, 1, 2, 0, 1);
    add(0, 0, 0, 2, 0, 1);
    add(0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0);
    // load priority and restart
    add(1, 9, 0, 9, 0, 1);
    add(0, 0, 1, 8, 0, 1);
    add(0, 0, 1, 7, 0, 1);
    add(0, 0, 1, 6, 0, 1);
    add(1, 2, 1, 2, 0, 1);
    add(0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0);
    // load 0 mid-count: idle, no tc
    add(1, 5, 1, 5, 0, 1);
    add(0, 0, 1, 4, 0, 1);
    add(1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    // leave DONE via load 1
    add(1, 1, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0);
`else
    // auto-reload: load 2 -> 2,1,0,2,1,0,2
    add(1, 2, 1, 2, 0, 1);
    add(0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 2, 0, 1);
    add(0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 2, 0, 1);
    add(0, 0, 0, 2, 0, 1);
    add(1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].load, int'(vecs[i].load_val), vecs[i].en);
      tick();
      check_outs($sformatf("vec%0d", i), int'(vecs[i].exp_q), int'(vecs[i].exp_tc), int'(vecs[i].exp_busy));
    end

    // max value: 15 enabled cycles to tc
    drive(1, 15, 0);
    tick();
    check_outs("max load", 15, 0, 1);
    drive(0, 0, 1);
    for (int i = 1; i < 15; i++) begin
      tick();
      check_outs($sformatf("max cnt%0d", i), 15 - i, 0, 1);
    end
    tick();
`ifndef DOWN_TIMER_AUTORELOAD_EN
    check_outs("max tc", 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs($sformatf("max hold%0d", i), 0, 0, 0);
    end
`else
    check_outs("max tc", 0, 1, 1);
    tick();
    check_outs("max reload", 15, 0, 1);
`endif

    // async reset mid-count at q = 5, between edges
    drive(1, 7, 0);
    tick();
    drive(0, 0, 1);
    tick();
    tick();
    check("pre-reset q", int'(q), 5);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async reset", 0, 0, 0);
    #1;
    rst = 1'b1;
    m_q = 0; m_reload = 0; m_active = 0; m_tc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("post-reset%0d", i), 0, 0, 0);
    end

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit ld;
      int lv;
      bit e;
      ld = ($urandom_range(0, 9) == 0);
      lv = (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)));
      e  = ($urandom_range(0, 3) != 0);
      drive(ld, lv, e);
      model_step(ld, lv, e);
      tick();
      check_outs($sformatf("rand%0d", i), m_q, int'(m_tc), int'(m_active));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
